// File: rtl/conv_sched_pkg.sv
// Shared constants, derived geometry and FSM encoding for the convolution tile scheduler.
// The tap counter and the top-level scheduler both import this package.
package conv_sched_pkg;

  localparam int NUM_OF_PE   = 256;
  localparam int KERNEL_SIZE = 3;
  localparam int IFM_C       = 3;
  localparam int OFM_W       = 32;
  localparam int OFM_C       = 2;
  localparam int PAD_W       = 34;
  localparam int PE_LAT      = 2;
  localparam int ADDR_W      = 16;

  localparam int TAPS_PER_TILE    = KERNEL_SIZE * KERNEL_SIZE * IFM_C;
  localparam int TILES_PER_FILTER = (OFM_W * OFM_W) / NUM_OF_PE;
  localparam int CH_STRIDE        = PAD_W * PAD_W;
  localparam int TILE_BX_STEP     = NUM_OF_PE % OFM_W;
  localparam int TILE_BY_STEP     = NUM_OF_PE / OFM_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [7:0]        coord_t;

  // IFM address deltas when kx wraps into the next row, and when ky also wraps into the next channel.
  localparam addr_t ROW_STEP = addr_t'(PAD_W - (KERNEL_SIZE - 1));
  localparam addr_t CH_STEP  = addr_t'(CH_STRIDE - (KERNEL_SIZE - 1) * PAD_W - (KERNEL_SIZE - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESTART,
    S_RUN,
    S_DRAIN,
    S_CAPTURE,
    S_DONE
  } state_e;

  function automatic addr_t tile_base(input coord_t bx, input coord_t by);
    return addr_t'(by) * addr_t'(PAD_W) + addr_t'(bx);
  endfunction

endpackage

// File: rtl/conv_tile_scheduler_if.sv
// Tap-descriptor, PE-strobe and OFM-capture signals between the scheduler and the fetcher/PE array.
interface conv_tile_scheduler_if;
  import conv_sched_pkg::*;

  logic   tap_valid;
  logic   tap_ready;
  coord_t tap_kx;
  coord_t tap_ky;
  coord_t tap_kz;
  logic   tap_last;
  coord_t tile_bx;
  coord_t tile_by;
  addr_t  ifm_addr;
  addr_t  wgt_addr;
  coord_t filter_idx;
  logic   pe_restart;
  logic   pe_finish;
  logic   ofm_valid;
  logic   ofm_ready;

  modport master (
    output tap_valid, tap_kx, tap_ky, tap_kz, tap_last, tile_bx, tile_by,
           ifm_addr, wgt_addr, filter_idx, pe_restart, pe_finish, ofm_valid,
    input  tap_ready, ofm_ready
  );

  modport slave (
    input  tap_valid, tap_kx, tap_ky, tap_kz, tap_last, tile_bx, tile_by,
           ifm_addr, wgt_addr, filter_idx, pe_restart, pe_finish, ofm_valid,
    output tap_ready, ofm_ready
  );

endinterface

// File: rtl/conv_tap_counter.sv
// Nested kernel-tap counter: kx fastest, then ky, then kz, with a flat tap index and last-tap flag.
module conv_tap_counter
  import conv_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output coord_t     kx,
  output coord_t     ky,
  output coord_t     kz,
  output logic [7:0] tap_index,
  output logic       last
);

  logic kx_wrap;
  logic ky_wrap;

  assign kx_wrap = (kx == coord_t'(KERNEL_SIZE - 1));
  assign ky_wrap = (ky == coord_t'(KERNEL_SIZE - 1));
  assign last    = kx_wrap && ky_wrap && (kz == coord_t'(IFM_C - 1));

  // NOTE: reset is synchronous, so it lives inside the clocked branch and not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      kx        <= '0;
      ky        <= '0;
      kz        <= '0;
      tap_index <= '0;
    end else if (en) begin
      tap_index <= last ? 8'd0 : tap_index + 8'd1;
      kx        <= kx_wrap ? coord_t'(0) : kx + coord_t'(1);
      if (kx_wrap) begin
        ky <= ky_wrap ? coord_t'(0) : ky + coord_t'(1);
        if (ky_wrap) kz <= last ? coord_t'(0) : kz + coord_t'(1);
      end
    end
  end

endmodule

// File: rtl/conv_tile_scheduler.sv
// Layer sequencer for the 256-PE convolution array: walks filters, tiles and kernel taps,
// issues registered tap descriptors to the fetcher and handshakes each finished tile out.
module conv_tile_scheduler
  import conv_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  conv_tile_scheduler_if.master bus
);

  if ((TILES_PER_FILTER * NUM_OF_PE != OFM_W * OFM_W) || (NUM_OF_PE > OFM_W * OFM_W)) begin : g_bad_tiling
    $error("OFM_W*OFM_W must be a whole multiple of NUM_OF_PE");
  end
  if (CH_STRIDE * IFM_C > 2 ** ADDR_W) begin : g_addr_overflow
    $error("padded IFM does not fit in ADDR_W address bits");
  end

  state_e     state;
  state_e     state_nxt;
  coord_t     kx, ky, kz;
  logic [7:0] tap_index;
  logic       cnt_last;
  coord_t     tile_bx, tile_by, filter_idx;
  coord_t     bx_sum;
  logic [7:0] tile_cnt;
  logic [7:0] drain_cnt;
  addr_t      ifm_addr, wgt_addr, ifm_step;
  logic       tap_hs, cap_hs, more_tiles, more_filters;

  assign tap_hs       = (state == S_RUN) && bus.tap_ready;
  assign cap_hs       = (state == S_CAPTURE) && bus.ofm_ready;
  assign more_tiles   = (tile_cnt != 8'(TILES_PER_FILTER - 1));
  assign more_filters = (filter_idx != coord_t'(OFM_C - 1));
  assign bx_sum       = tile_bx + coord_t'(TILE_BX_STEP);

  conv_tap_counter u_taps (
    .clk       (clk),
    .rst       (rst),
    .en        (tap_hs),
    .clr       (state == S_RESTART),
    .kx        (kx),
    .ky        (ky),
    .kz        (kz),
    .tap_index (tap_index),
    .last      (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start) state_nxt = S_RESTART;
      S_RESTART: state_nxt = S_RUN;
      S_RUN:     if (tap_hs && cnt_last) state_nxt = S_DRAIN;
      S_DRAIN:   if (drain_cnt == 8'(PE_LAT - 1)) state_nxt = S_CAPTURE;
      S_CAPTURE: if (cap_hs) state_nxt = (more_tiles || more_filters) ? S_RESTART : S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ifm_step = addr_t'(1);
    if (kx == coord_t'(KERNEL_SIZE - 1))
      ifm_step = (ky == coord_t'(KERNEL_SIZE - 1)) ? CH_STEP : ROW_STEP;
  end

  // NOTE: nonblocking assignments so every register here samples the pre-edge counter and state values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_bx    <= '0;
      tile_by    <= '0;
      filter_idx <= '0;
      tile_cnt   <= '0;
      drain_cnt  <= '0;
      ifm_addr   <= '0;
      wgt_addr   <= '0;
    end else begin
      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 8'd1 : 8'd0;
      // Addresses are loaded for tap 0 during RESTART so they line up with the first tap_valid.
      if (state == S_RESTART) begin
        ifm_addr <= tile_base(tile_bx, tile_by);
        wgt_addr <= addr_t'(filter_idx) * addr_t'(TAPS_PER_TILE);
      end else if (tap_hs) begin
        ifm_addr <= ifm_addr + ifm_step;
        wgt_addr <= addr_t'(filter_idx) * addr_t'(TAPS_PER_TILE) + addr_t'(tap_index) + addr_t'(1);
      end
      if (cap_hs) begin
        if (more_tiles) begin
          tile_cnt <= tile_cnt + 8'd1;
          if (bx_sum >= coord_t'(OFM_W)) begin
            tile_bx <= bx_sum - coord_t'(OFM_W);
            tile_by <= tile_by + coord_t'(TILE_BY_STEP + 1);
          end else begin
            tile_bx <= bx_sum;
            tile_by <= tile_by + coord_t'(TILE_BY_STEP);
          end
        end else begin
          tile_cnt   <= '0;
          tile_bx    <= '0;
          tile_by    <= '0;
          filter_idx <= more_filters ? filter_idx + coord_t'(1) : coord_t'(0);
        end
      end
    end
  end

  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign bus.pe_restart = (state == S_RESTART);
  assign bus.tap_valid  = (state == S_RUN);
  assign bus.ofm_valid  = (state == S_CAPTURE);
  assign bus.pe_finish  = tap_hs && cnt_last;
  assign bus.tap_last   = cnt_last;
  assign bus.tap_kx     = kx;
  assign bus.tap_ky     = ky;
  assign bus.tap_kz     = kz;
  assign bus.tile_bx    = tile_bx;
  assign bus.tile_by    = tile_by;
  assign bus.filter_idx = filter_idx;
  assign bus.ifm_addr   = ifm_addr;
  assign bus.wgt_addr   = wgt_addr;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Self-checking bench for conv_tile_scheduler: a loop-nest reference model of the whole layer,
// a table of hand-computed tap descriptors, and directed back-pressure / abort sequences.
module tb_conv_tile_scheduler;
  import conv_sched_pkg::*;

  localparam int TOTAL_TAPS = OFM_C * TILES_PER_FILTER * TAPS_PER_TILE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy;
  logic done;

  conv_tile_scheduler_if bus ();

  conv_tile_scheduler dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .busy  (busy),
    .done  (done),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    coord_t kx, ky, kz;
    logic   last;
    coord_t bx, by, fidx;
    addr_t  ifm, wgt;
  } desc_t;

  typedef struct {
    int    idx;
    desc_t exp;
  } vec_t;

  desc_t exp_q[$];
  desc_t cap[TOTAL_TAPS];
  int    n_checks = 0;
  int    n_fail = 0;
  int    n_hs = 0;
  int    n_restart = 0;
  int    n_capture = 0;
  int    n_done = 0;
  bit    mon_en = 1'b0;
  bit    tap_rand = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic logic [127:0] desc_bits(input desc_t d);
    return {47'd0, d.kx, d.ky, d.kz, d.bx, d.by, d.fidx, d.ifm, d.wgt, d.last};
  endfunction

  function automatic desc_t dut_desc();
    desc_t d;
    d.kx = bus.tap_kx;  d.ky = bus.tap_ky;  d.kz = bus.tap_kz;  d.last = bus.tap_last;
    d.bx = bus.tile_bx; d.by = bus.tile_by; d.fidx = bus.filter_idx;
    d.ifm = bus.ifm_addr; d.wgt = bus.wgt_addr;
    return d;
  endfunction

  function automatic logic [127:0] outs_bits();
    return {41'd0, busy, done, bus.tap_valid, bus.tap_kx, bus.tap_ky, bus.tap_kz, bus.tap_last,
            bus.tile_bx, bus.tile_by, bus.ifm_addr, bus.wgt_addr, bus.filter_idx,
            bus.pe_restart, bus.pe_finish, bus.ofm_valid};
  endfunction

  function automatic desc_t mk(input int kx, ky, kz, last, bx, by, fidx, ifm, wgt);
    desc_t d;
    d.kx = coord_t'(kx); d.ky = coord_t'(ky); d.kz = coord_t'(kz); d.last = (last != 0);
    d.bx = coord_t'(bx); d.by = coord_t'(by); d.fidx = coord_t'(fidx);
    d.ifm = addr_t'(ifm); d.wgt = addr_t'(wgt);
    return d;
  endfunction

  // Whole-layer expectation from the address formulas: tile base from the flat pixel index.
  task automatic build_model();
    exp_q.delete();
    for (int f = 0; f < OFM_C; f++) begin
      for (int t = 0; t < TILES_PER_FILTER; t++) begin
        int pix = t * NUM_OF_PE;
        int bx = pix % OFM_W;
        int by = pix / OFM_W;
        for (int kz = 0; kz < IFM_C; kz++)
          for (int ky = 0; ky < KERNEL_SIZE; ky++)
            for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
              int tap = (kz * KERNEL_SIZE + ky) * KERNEL_SIZE + kx;
              exp_q.push_back(mk(kx, ky, kz, int'(tap == TAPS_PER_TILE - 1), bx, by, f,
                                 (by + ky) * PAD_W + bx + kx + kz * PAD_W * PAD_W,
                                 f * TAPS_PER_TILE + tap));
            end
      end
    end
  endtask

  task automatic reset_counts();
    n_hs = 0; n_restart = 0; n_capture = 0; n_done = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Counts clock edges after the edge that sampled start until done is seen high.
  task automatic wait_done(input int budget, output int cyc);
    bit seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < budget) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      seen = done;
    end
    if (!seen) fail("done_timeout");
  endtask

  task automatic check_layer_counts(input string tag);
    check({tag, "_restarts"}, 128'(n_restart), 128'(OFM_C * TILES_PER_FILTER));
    check({tag, "_handshakes"}, 128'(n_hs), 128'(TOTAL_TAPS));
    check({tag, "_captures"}, 128'(n_capture), 128'(OFM_C * TILES_PER_FILTER));
    check({tag, "_model_left"}, 128'(exp_q.size()), 128'(0));
    check({tag, "_done_pulses"}, 128'(n_done), 128'(1));
  endtask

  always @(negedge clk) begin
    if (!rst && mon_en) begin
      if (bus.pe_restart) n_restart++;
      if (bus.ofm_valid && bus.ofm_ready) n_capture++;
      if (done) n_done++;
      if (bus.tap_valid) begin
        if (exp_q.size() == 0) begin
          fail("tap_unexpected");
        end else begin
          check("tap_desc", desc_bits(dut_desc()), desc_bits(exp_q[0]));
          if (bus.tap_ready) begin
            check("pe_finish", 128'(bus.pe_finish), 128'(exp_q[0].last));
            if (n_hs < TOTAL_TAPS) cap[n_hs] = dut_desc();
            n_hs++;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        check("pe_finish_idle", 128'(bus.pe_finish), 128'(0));
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1 bus.tap_ready = tap_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    vec_t vecs[9];
    int   cyc;

    vecs[0] = '{0,   mk(0, 0, 0, 0, 0, 0,  0, 0,    0)};
    vecs[1] = '{1,   mk(1, 0, 0, 0, 0, 0,  0, 1,    1)};
    vecs[2] = '{3,   mk(0, 1, 0, 0, 0, 0,  0, 34,   3)};
    vecs[3] = '{9,   mk(0, 0, 1, 0, 0, 0,  0, 1156, 9)};
    vecs[4] = '{26,  mk(2, 2, 2, 1, 0, 0,  0, 2382, 26)};
    vecs[5] = '{27,  mk(0, 0, 0, 0, 0, 8,  0, 272,  0)};
    vecs[6] = '{81,  mk(0, 0, 0, 0, 0, 24, 0, 816,  0)};
    vecs[7] = '{108, mk(0, 0, 0, 0, 0, 0,  1, 0,    27)};
    vecs[8] = '{215, mk(2, 2, 2, 1, 0, 24, 1, 3198, 53)};

    bus.tap_ready = 1'b1;
    bus.ofm_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", outs_bits(), 128'(0));
    @(posedge clk); #1 rst = 1'b0;

    // Full layer with no back-pressure: latency, strobe counts, and the descriptor table.
    build_model();
    reset_counts();
    mon_en = 1'b1;
    pulse_start();
    @(negedge clk);
    check("busy_after_start", 128'(busy), 128'(1));
    wait_done(400, cyc);
    check("done_latency", 128'(cyc), 128'(248));
    @(negedge clk);
    check("busy_after_done", 128'(busy), 128'(0));
    check_layer_counts("full");
    for (int i = 0; i < 9; i++)
      check($sformatf("vec_tap%0d", vecs[i].idx), desc_bits(cap[vecs[i].idx]), desc_bits(vecs[i].exp));

    // Random tap_ready: descriptors must hold while stalled and stay in model order.
    build_model();
    reset_counts();
    tap_rand = 1'b1;
    pulse_start();
    wait_done(3000, cyc);
    tap_rand = 1'b0;
    @(negedge clk);
    check_layer_counts("rand_ready");

    // OFM writer stalls the first capture for 10 cycles; a start pulse lands meanwhile.
    build_model();
    reset_counts();
    bus.ofm_ready = 1'b0;
    pulse_start();
    cyc = 0;
    while (!bus.ofm_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.ofm_valid) fail("ofm_valid_timeout");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 start = (i == 3);
      @(negedge clk);
      check("ofm_valid_held", 128'(bus.ofm_valid), 128'(1));
      check("no_restart_stalled", 128'(bus.pe_restart), 128'(0));
    end
    @(posedge clk); #1 bus.ofm_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("restart_after_capture", 128'(bus.pe_restart), 128'(1));
    wait_done(400, cyc);
    repeat (3) @(negedge clk);
    check("start_ignored_busy", 128'(busy), 128'(0));
    check_layer_counts("ofm_stall");

    // Reset mid-RUN of tile 2 aborts without done; the next start begins from scratch.
    build_model();
    reset_counts();
    pulse_start();
    cyc = 0;
    while (n_hs < 2 * TAPS_PER_TILE + 5 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    if (n_hs < 2 * TAPS_PER_TILE + 5) fail("tile2_timeout");
    mon_en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_outputs", outs_bits(), 128'(0));
    check("no_done_on_abort", 128'(n_done), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    build_model();
    reset_counts();
    mon_en = 1'b1;
    pulse_start();
    wait_done(400, cyc);
    check("restart_latency", 128'(cyc), 128'(248));
    @(negedge clk);
    check_layer_counts("after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
